sram_ctrl_param: RTL and testbench
==================================

Name: sram_ctrl_param

Overview:
Parametrised SRAM controller between the ARM pipeline MEM stage and the external 16-bit asynchronous SRAM model. It splits each DATA_W-bit load/store into DATA_W/SRAM_DW sequential SRAM beats, each held for WAIT_CYCLES clocks. It drives a ready signal that freezes the pipeline until the access completes. It generalises the fixed 32-on-16 two-beat controller with configurable widths, wait states, base-address offset and write-over-read priority.

Parameters:
DATA_W, 32, CPU-side word width; integer multiple of SRAM_DW
SRAM_DW, 16, SRAM data bus width
SRAM_AW, 18, SRAM address width
WAIT_CYCLES, 5, clocks each beat is held on the bus; must be >= 1
ADDR_BASE, 1024, byte address subtracted from the CPU address before translation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  store request from MEM stage
rd_en  in  1  load request from MEM stage
address  in  32  CPU byte address
write_data  in  DATA_W  store data
read_data  out  DATA_W  load result; valid in the DONE cycle, held until the next load completes
ready  out  1  0 = freeze pipeline
sram_dq  inout  SRAM_DW  SRAM data bus; high-Z unless writing
sram_addr  out  SRAM_AW  SRAM word address
sram_ctrl  out  5  {we_n, ub_n, lb_n, ce_n, oe_n}

Behaviour:
- Reset, asynchronous, any state: state=IDLE, beat=0, wait counter=0, read_data=0, sram_addr=0, sram_ctrl=5'b11111 (idle, we_n=1), sram_dq high-Z. ready=1 whenever there is no request.
- BEATS = DATA_W/SRAM_DW.
- word = (address - ADDR_BASE) >> log2(DATA_W/8).
- sram_addr = word*BEATS + beat, truncated to SRAM_AW.
- Beat 0 carries the least-significant SRAM_DW bits (little-endian).
- FSM IDLE:
  - ready = ~(wr_en|rd_en), combinational.
  - On a request, latch op, address and write_data at the clock edge, then go to ACCESS.
  - If wr_en and rd_en are both high, the request is a write.
- FSM ACCESS:
  - ready=0.
  - ub_n=lb_n=ce_n=0.
  - Write: we_n=0, oe_n=1, sram_dq drives the latched slice.
  - Read: we_n=1, oe_n=0, sram_dq high-Z. Sample sram_dq into read-slice[beat] on the last wait cycle of the beat (counter==WAIT_CYCLES-1).
  - The counter wraps 0..WAIT_CYCLES-1, then beat increments. After beat BEATS-1 wraps, go to DONE.
- FSM DONE:
  - ready=1 for exactly one cycle; sram_ctrl back to the idle value.
  - For a read, read_data updates on entry to DONE.
  - Next state is IDLE unconditionally. A request still present in IDLE on the following cycle is treated as a new access.
- Latency: ready is low for 1 + BEATS*WAIT_CYCLES cycles (11 with defaults), then high in DONE.
- Request deasserted mid-ACCESS: the access still completes. Operations are atomic; inputs are ignored after latching.
- Write: read_data is unchanged.
- Address below ADDR_BASE: wraps modulo 2^SRAM_AW; no error flag.
- rst asserted mid-ACCESS: the bus is released immediately and the partial write is abandoned. Already-written beats stay in the SRAM.

Decomposition:
- Shared package/include holds:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - sram_ctrl idle constant 5'b11111 and bit-index names for we_n/ub_n/lb_n/ce_n/oe_n.
  - A clog2 function.
- One sub-module: sram_beat_counter (WAIT_CYCLES/BEATS nested counter producing beat index, last_wait, last_beat).
- Datapath and tristate stay in the top.

Test Plan:
- Reset: rst=1 for 100 ns with wr_en=1 -> ready=1, sram_ctrl=5'b11111, sram_dq=Z, read_data=0; release -> write begins next edge.
- Store 0xDEADBEEF to address 1028 (word 1) with defaults -> sram_addr 2 holds 0xBEEF and sram_addr 3 holds 0xDEAD; ready low exactly 11 cycles, then high 1 cycle.
- Load address 1028 after the store -> read_data=0xDEADBEEF in the DONE cycle; we_n=1 throughout; sram_dq never driven by the controller.
- Simultaneous wr_en=rd_en=1 with write_data 0x12345678 at 1024 -> write performed (SRAM[0]=0x5678, SRAM[1]=0x1234); read_data unchanged.
- Re-parametrise DATA_W=64, WAIT_CYCLES=2: store 0x0123456789ABCDEF at 1032 -> SRAM[4..7]=CDEF,89AB,4567,0123; ready low 9 cycles; load returns the same value.
- rst pulse during beat 1 of a store -> sram_ctrl=5'b11111 asynchronously, FSM in IDLE, SRAM beat 0 written, beat 1 not; the next load completes normally.

Source files
------------

// File: rtl/sram_ctrl_param_pkg.sv
// Shared definitions for the parametrised SRAM controller: FSM encoding,
// SRAM control-bus constants and a width helper.
package sram_ctrl_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateT;

    // sram_ctrl = {we_n, ub_n, lb_n, ce_n, oe_n}
    localparam logic [4:0] SRAM_CTRL_IDLE = 5'b11111;
    localparam int WE_N = 4;
    localparam int UB_N = 3;
    localparam int LB_N = 2;
    localparam int CE_N = 1;
    localparam int OE_N = 0;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_beat_counter.sv
// Nested wait/beat counter: each beat lasts WAIT_CYCLES clocks, BEATS beats per access.
// Held at zero whenever en is low so every access starts at beat 0, wait 0.
module sram_beat_counter
    import sram_ctrl_param_pkg::*;
#(
    parameter int WAIT_CYCLES = 5,
    parameter int BEATS       = 2,
    localparam int CW = (WAIT_CYCLES > 1) ? clog2(WAIT_CYCLES) : 1,
    localparam int BW = (BEATS > 1) ? clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [BW-1:0] beat,
    output logic          lastWait,
    output logic          lastBeat
);

    logic [CW-1:0] waitCnt;

    assign lastWait = (waitCnt == CW'(WAIT_CYCLES - 1));
    assign lastBeat = (beat == BW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
            beat    <= '0;
        end else if (!en) begin
            waitCnt <= '0;
            beat    <= '0;
        end else if (lastWait) begin
            waitCnt <= '0;
            beat    <= lastBeat ? '0 : beat + 1'b1;
        end else begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_ctrl_param.sv
// SRAM controller between the MEM stage and a narrow asynchronous SRAM: splits each
// DATA_W access into little-endian SRAM_DW beats and stalls the pipeline via ready.
module sram_ctrl_param
    import sram_ctrl_param_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [4:0]         sram_ctrl,
    output stateT              dbgState
);

    localparam int BEATS      = DATA_W / SRAM_DW;
    localparam int BYTE_SHIFT = clog2(DATA_W / 8);
    localparam int BW         = (BEATS > 1) ? clog2(BEATS) : 1;

    stateT state, nextState;

    logic               isWrite;
    logic [SRAM_AW-1:0] wordReg;
    logic [DATA_W-1:0]  writeReg;
    logic [DATA_W-1:0]  readBuf;
    logic [DATA_W-1:0]  readDataReg;
    logic [DATA_W-1:0]  mergedRead;
    logic [SRAM_DW-1:0] writeSlice;
    logic               driveDq;
    logic               request;
    logic [BW-1:0]      beat;
    logic               lastWait;
    logic               lastBeat;

    assign request = wr_en | rd_en;

    sram_beat_counter #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .BEATS      (BEATS)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ACCESS),
        .beat    (beat),
        .lastWait(lastWait),
        .lastBeat(lastBeat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        ready     = 1'b1;
        sram_ctrl = SRAM_CTRL_IDLE;
        driveDq   = 1'b0;
        case (state)
            IDLE: begin
                // Held high while in reset even if a request is pending.
                ready = ~(request & ~rst);
                if (request) nextState = ACCESS;
            end
            ACCESS: begin
                ready           = 1'b0;
                sram_ctrl[UB_N] = 1'b0;
                sram_ctrl[LB_N] = 1'b0;
                sram_ctrl[CE_N] = 1'b0;
                if (isWrite) begin
                    sram_ctrl[WE_N] = 1'b0;
                    driveDq         = 1'b1;
                end else begin
                    sram_ctrl[OE_N] = 1'b0;
                end
                if (lastWait && lastBeat) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Current read buffer with the live bus value dropped into this beat's slice.
    always_comb begin
        mergedRead = readBuf;
        mergedRead[int'(beat)*SRAM_DW +: SRAM_DW] = sram_dq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isWrite     <= 1'b0;
            wordReg     <= '0;
            writeReg    <= '0;
            readBuf     <= '0;
            readDataReg <= '0;
        end else begin
            if (state == IDLE && request) begin
                isWrite  <= wr_en;
                wordReg  <= SRAM_AW'((address - 32'(ADDR_BASE)) >> BYTE_SHIFT);
                writeReg <= write_data;
            end
            if (state == ACCESS && !isWrite && lastWait) begin
                readBuf <= mergedRead;
                // Final beat goes straight to the output so it is valid in DONE.
                if (lastBeat) readDataReg <= mergedRead;
            end
        end
    end

    assign writeSlice = writeReg[int'(beat)*SRAM_DW +: SRAM_DW];
    assign sram_dq    = driveDq ? writeSlice : {SRAM_DW{1'bz}};
    assign sram_addr  = SRAM_AW'(wordReg * SRAM_AW'(BEATS) + SRAM_AW'(beat));
    assign read_data  = readDataReg;
    assign dbgState   = state;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: a default 32-on-16 instance (A) and a 64-bit, 2-wait instance (B),
// each with its own behavioural SRAM, a directed vector table, random traffic and reset corners.
module tb_sram_ctrl_param;
  import sram_ctrl_param_pkg::*;

  localparam int DEPTH = 1 << 18;
  localparam int WAIT_A = 5;
  localparam int WAIT_B = 2;
  localparam int BEATS_A = 2;
  localparam int BEATS_B = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  logic        wr_a, rd_a, ready_a;
  logic [31:0] addr_a, wd_a, read_a;
  wire  [15:0] dq_a;
  logic [17:0] saddr_a;
  logic [4:0]  ctrl_a;
  stateT       st_a;

  sram_ctrl_param dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(addr_a),
    .write_data(wd_a), .read_data(read_a), .ready(ready_a), .sram_dq(dq_a),
    .sram_addr(saddr_a), .sram_ctrl(ctrl_a), .dbgState(st_a)
  );

  // ---------------- DUT B (64-bit, 2 wait cycles) ----------------
  logic        wr_b, rd_b, ready_b;
  logic [31:0] addr_b;
  logic [63:0] wd_b, read_b;
  wire  [15:0] dq_b;
  logic [17:0] saddr_b;
  logic [4:0]  ctrl_b;
  stateT       st_b;

  sram_ctrl_param #(.DATA_W(64), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .address(addr_b),
    .write_data(wd_b), .read_data(read_b), .ready(ready_b), .sram_dq(dq_b),
    .sram_addr(saddr_b), .sram_ctrl(ctrl_b), .dbgState(st_b)
  );

  // ---------------- SRAM models ----------------
  // A beat only lands in memory once the write has been held for the full wait time.
  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];
  int          hold_a, hold_b;
  logic [17:0] hold_addr_a, hold_addr_b;

  assign dq_a = (!ctrl_a[CE_N] && !ctrl_a[OE_N] && ctrl_a[WE_N]) ? mem_a[saddr_a] : 16'bz;
  assign dq_b = (!ctrl_b[CE_N] && !ctrl_b[OE_N] && ctrl_b[WE_N]) ? mem_b[saddr_b] : 16'bz;

  always @(negedge clk) begin
    if (!ctrl_a[WE_N] && !ctrl_a[CE_N]) begin
      if (hold_a > 0 && saddr_a == hold_addr_a) hold_a = hold_a + 1;
      else begin hold_a = 1; hold_addr_a = saddr_a; end
      if (hold_a == WAIT_A) mem_a[saddr_a] = dq_a;
    end else hold_a = 0;
    if (!ctrl_b[WE_N] && !ctrl_b[CE_N]) begin
      if (hold_b > 0 && saddr_b == hold_addr_b) hold_b = hold_b + 1;
      else begin hold_b = 1; hold_addr_b = saddr_b; end
      if (hold_b == WAIT_B) mem_b[saddr_b] = dq_b;
    end else hold_b = 0;
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_a [int];
  logic [15:0] ref_b [int];
  logic [63:0] last_rd_a, last_rd_b;

  function automatic int sram_index(input bit big, input logic [31:0] addr, input int b);
    logic [31:0] w;
    w = (addr - 32'd1024) >> (big ? 3 : 2);
    return int'((w * (big ? BEATS_B : BEATS_A) + b) & 32'h3FFFF);
  endfunction

  function automatic logic [15:0] ref_get(input bit big, input int idx);
    if (big) return ref_b.exists(idx) ? ref_b[idx] : 16'h0;
    return ref_a.exists(idx) ? ref_a[idx] : 16'h0;
  endfunction

  function automatic void ref_store(input bit big, input logic [31:0] addr, input logic [63:0] d);
    for (int b = 0; b < (big ? BEATS_B : BEATS_A); b++) begin
      if (big) ref_b[sram_index(1'b1, addr, b)] = d[b*16 +: 16];
      else     ref_a[sram_index(1'b0, addr, b)] = d[b*16 +: 16];
    end
  endfunction

  function automatic logic [63:0] ref_load(input bit big, input logic [31:0] addr);
    logic [63:0] r;
    r = 64'h0;
    for (int b = 0; b < (big ? BEATS_B : BEATS_A); b++)
      r[b*16 +: 16] = ref_get(big, sram_index(big, addr, b));
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int compared = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input bit big, input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [63:0] wd, output int low_cyc, output logic [63:0] rdata,
                           output bit we_low_on_read, output bit timed_out);
    @(negedge clk);
    if (big) begin wr_b = wr; rd_b = rd; addr_b = addr; wd_b = wd; end
    else begin wr_a = wr; rd_a = rd; addr_a = addr; wd_a = wd[31:0]; end
    #1;
    low_cyc = ((big ? ready_b : ready_a) == 1'b0) ? 1 : 0;
    @(posedge clk);
    #1;
    wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
    timed_out = 1'b1;
    we_low_on_read = 1'b0;
    rdata = 64'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (big ? ready_b : ready_a) begin
        rdata = big ? read_b : {32'h0, read_a};
        timed_out = 1'b0;
        break;
      end
      low_cyc++;
      if (!wr && !(big ? ctrl_b[WE_N] : ctrl_a[WE_N])) we_low_on_read = 1'b1;
    end
  endtask

  // Runs one access through the model and scoreboard and checks latency and read_data.
  task automatic run_op(input string name, input bit big, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [63:0] wd);
    int low;
    logic [63:0] rdata, exp;
    bit we_low, tmo;
    if (wr) begin
      ref_store(big, addr, wd);
      exp_q.push_back(big ? last_rd_b : last_rd_a);
    end else begin
      exp = ref_load(big, addr);
      exp_q.push_back(exp);
      if (big) last_rd_b = exp; else last_rd_a = exp;
    end
    do_access(big, wr, rd, addr, wd, low, rdata, we_low, tmo);
    check({name, "_timeout"}, 64'(tmo), 64'd0);
    check({name, "_ready_low_cycles"}, 64'(low), 64'(big ? 1 + BEATS_B*WAIT_B : 1 + BEATS_A*WAIT_A));
    check({name, "_read_data"}, rdata, exp_q.pop_front());
    if (!wr) check({name, "_we_n_during_read"}, 64'(we_low), 64'd0);
  endtask

  typedef struct {
    bit          big;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [63:0] wd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    bit tmo;
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
    hold_a = 0; hold_b = 0; hold_addr_a = '0; hold_addr_b = '0;
    last_rd_a = 64'h0; last_rd_b = 64'h0;
    wr_b = 1'b0; rd_b = 1'b0; addr_b = 32'h0; wd_b = 64'h0;

    // Reset held 100 ns with a store pending on A.
    rst = 1'b1; wr_a = 1'b1; rd_a = 1'b0; addr_a = 32'd1024; wd_a = 32'hA5A5_0F0F;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_a", 64'(ready_a), 64'd1);
    check("rst_ctrl_a", 64'(ctrl_a), 64'h1F);
    check("rst_read_a", 64'(read_a), 64'h0);
    check("rst_saddr_a", 64'(saddr_a), 64'h0);
    check("rst_state_a", 64'(st_a), 64'(IDLE));
    check("rst_ctrl_b", 64'(ctrl_b), 64'h1F);
    check("rst_read_b", read_b, 64'h0);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready_a", 64'(ready_a), 64'd0);
    @(posedge clk);
    #1;
    wr_a = 1'b0;
    @(negedge clk);
    check("first_write_ctrl", 64'(ctrl_a), 64'h01);
    check("first_write_addr", 64'(saddr_a), 64'h0);
    tmo = 1'b1;
    low = 2;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_a) begin tmo = 1'b0; break; end
      low++;
    end
    check("first_write_timeout", 64'(tmo), 64'd0);
    check("first_write_low_cycles", 64'(low), 64'd11);
    ref_store(1'b0, 32'd1024, 64'hA5A5_0F0F);
    check("first_write_mem0", 64'(mem_a[0]), 64'h0F0F);
    check("first_write_mem1", 64'(mem_a[1]), 64'hA5A5);

    // Directed vector table.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'd1028, 64'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'd1028, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'd1024, 64'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'd1024, 64'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'd1032, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'd1032, 64'h0};
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].big, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd);
    check("mem_a2", 64'(mem_a[2]), 64'hBEEF);
    check("mem_a3", 64'(mem_a[3]), 64'hDEAD);
    check("mem_a0", 64'(mem_a[0]), 64'h5678);
    check("mem_a1", 64'(mem_a[1]), 64'h1234);
    check("mem_b4", 64'(mem_b[4]), 64'hCDEF);
    check("mem_b5", 64'(mem_b[5]), 64'h89AB);
    check("mem_b6", 64'(mem_b[6]), 64'h4567);
    check("mem_b7", 64'(mem_b[7]), 64'h0123);

    // Random traffic, including addresses below the base.
    for (int i = 0; i < 60; i++) begin
      bit big;
      int kind, bytes;
      logic [31:0] addr;
      logic [63:0] d;
      big = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      bytes = big ? 8 : 4;
      if ($urandom_range(0, 7) == 0) addr = 32'(1024 - bytes * $urandom_range(1, 4));
      else addr = 32'(1024 + bytes * $urandom_range(0, 15));
      d = {32'($urandom), 32'($urandom)};
      if (!big) d[63:32] = 32'h0;
      run_op($sformatf("rand%0d", i), big, kind != 2, kind >= 2, addr, d);
    end

    // Reset during beat 1 of a store to word 10 (SRAM 20/21).
    @(negedge clk);
    wr_a = 1'b1; addr_a = 32'd1064; wd_a = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    wr_a = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ctrl", 64'(ctrl_a), 64'h1F);
    check("midrst_state", 64'(st_a), 64'(IDLE));
    check("midrst_ready", 64'(ready_a), 64'd1);
    check("midrst_read_data", 64'(read_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd_a = 64'h0; last_rd_b = 64'h0;
    ref_a[20] = 16'hF00D;
    check("midrst_beat0_written", 64'(mem_a[20]), 64'hF00D);
    check("midrst_beat1_kept", 64'(mem_a[21]), 64'(ref_get(1'b0, 21)));
    run_op("load_after_rst", 1'b0, 1'b0, 1'b1, 32'd1064, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
